// File: rtl/stw_bisr_sequencer.sv
// Built-in self-test and self-repair sequencer for a ROWS x COLS PE array: drives LFSR
// test patterns, accumulates per-PE failures, then maps faulty PEs onto redundant units.
module stw_bisr_sequencer #(
    parameter int                   ROWS         = 4,
    parameter int                   COLS         = 4,
    parameter int                   WORD_SIZE    = 16,
    parameter int                   NUM_RU       = 4,
    parameter int                   NUM_PATTERNS = 4,
    parameter logic [WORD_SIZE-1:0] SEED         = 16'hACE1,
    parameter logic [WORD_SIZE-1:0] TAPS         = 16'hB400,
    parameter int                   TIMEOUT      = 64,
    localparam int                  RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int                  CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   STW_start,
    input  logic                   STW_result_valid,
    input  logic [ROWS*COLS-1:0]   STW_result_mat,
    output logic                   STW_test_load_en,
    output logic                   STW_pe_start,
    output logic [WORD_SIZE-1:0]   STW_mult_op1,
    output logic [WORD_SIZE-1:0]   STW_mult_op2,
    output logic [WORD_SIZE-1:0]   STW_add_op,
    output logic [WORD_SIZE-1:0]   STW_expected,
    output logic [ROWS*COLS-1:0]   fault_map,
    output logic [NUM_RU*RW-1:0]   ru_row_mapping,
    output logic [NUM_RU*CW-1:0]   ru_col_mapping,
    output logic [NUM_RU-1:0]      ru_valid,
    output logic                   busy,
    output logic                   STW_complete,
    output logic                   matrix_start,
    output logic                   repair_fail,
    output logic                   STW_timeout
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int KW = $clog2(NUM_RU + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_ALLOC, S_DONE} state_t;

    state_t                     state, state_nx;
    logic [WORD_SIZE-1:0]       lfsr, lfsr_next, pat_src;
    logic [WORD_SIZE-1:0]       pat_op1, pat_op2, pat_add, pat_exp;
    logic [PW-1:0]              pat_idx;
    logic [TW-1:0]              tmo_cnt;
    logic [IW-1:0]              scan_idx;
    logic [RW-1:0]              scan_row;
    logic [CW-1:0]              scan_col;
    logic [KW-1:0]              ru_cnt;
    logic [NUM_RU-1:0][RW-1:0]  ru_row;
    logic [NUM_RU-1:0][CW-1:0]  ru_col;
    logic                       res_take, tmo_hit, last_pat, scan_last;

    assign ru_row_mapping = ru_row;
    assign ru_col_mapping = ru_col;

    assign res_take  = (state == S_WAIT) && STW_result_valid;
    assign tmo_hit   = (state == S_WAIT) && !STW_result_valid && (tmo_cnt == TW'(TIMEOUT - 1));
    assign last_pat  = (pat_idx == PW'(NUM_PATTERNS - 1));
    assign scan_last = (scan_row == RW'(ROWS - 1)) && (scan_col == CW'(COLS - 1));

    // Pattern generation: the next pattern is registered on the edge that enters LOAD.
    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        pat_src   = (state == S_IDLE) ? SEED : lfsr_next;
        pat_op1   = pat_src;
        pat_op2   = ~pat_src;
        pat_add   = {pat_src[WORD_SIZE-2:0], pat_src[WORD_SIZE-1]};
        pat_exp   = pat_op1 * pat_op2 + pat_add;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx         = state;
        STW_test_load_en = 1'b0;
        STW_pe_start     = 1'b0;
        STW_complete     = 1'b0;
        busy             = (state != S_IDLE);
        unique case (state)
            S_IDLE:  if (STW_start) state_nx = S_LOAD;
            S_LOAD:  begin
                STW_test_load_en = 1'b1;
                state_nx         = S_RUN;
            end
            S_RUN:   begin
                STW_pe_start = 1'b1;
                state_nx     = S_WAIT;
            end
            S_WAIT:  begin
                if (res_take)     state_nx = last_pat ? S_ALLOC : S_LOAD;
                else if (tmo_hit) state_nx = S_DONE;
            end
            S_ALLOC: if (scan_last) state_nx = S_DONE;
            S_DONE:  begin
                STW_complete = 1'b1;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr         <= SEED;
            STW_mult_op1 <= '0;
            STW_mult_op2 <= '0;
            STW_add_op   <= '0;
            STW_expected <= '0;
            pat_idx      <= '0;
            tmo_cnt      <= '0;
            scan_idx     <= '0;
            scan_row     <= '0;
            scan_col     <= '0;
            ru_cnt       <= '0;
            ru_row       <= '0;
            ru_col       <= '0;
            ru_valid     <= '0;
            fault_map    <= '0;
            repair_fail  <= 1'b0;
            STW_timeout  <= 1'b0;
            matrix_start <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (STW_start) begin
                    lfsr         <= SEED;
                    STW_mult_op1 <= pat_op1;
                    STW_mult_op2 <= pat_op2;
                    STW_add_op   <= pat_add;
                    STW_expected <= pat_exp;
                    pat_idx      <= '0;
                    ru_cnt       <= '0;
                    ru_row       <= '0;
                    ru_col       <= '0;
                    ru_valid     <= '0;
                    fault_map    <= '0;
                    repair_fail  <= 1'b0;
                    STW_timeout  <= 1'b0;
                    matrix_start <= 1'b0;
                end
                S_RUN: tmo_cnt <= '0;
                S_WAIT: begin
                    if (res_take) begin
                        fault_map <= fault_map | ~STW_result_mat;
                        lfsr      <= lfsr_next;
                        pat_idx   <= pat_idx + 1'b1;
                        if (last_pat) begin
                            scan_idx <= '0;
                            scan_row <= '0;
                            scan_col <= '0;
                        end else begin
                            STW_mult_op1 <= pat_op1;
                            STW_mult_op2 <= pat_op2;
                            STW_add_op   <= pat_add;
                            STW_expected <= pat_exp;
                        end
                    end else if (tmo_hit) begin
                        STW_timeout <= 1'b1;
                        repair_fail <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_ALLOC: begin
                    // Lowest free RU is always index ru_cnt since RUs are handed out in order.
                    if (fault_map[scan_idx]) begin
                        if (ru_cnt == KW'(NUM_RU)) begin
                            repair_fail <= 1'b1;
                        end else begin
                            for (int k = 0; k < NUM_RU; k++) begin
                                if (ru_cnt == KW'(k)) begin
                                    ru_valid[k] <= 1'b1;
                                    ru_row[k]   <= scan_row;
                                    ru_col[k]   <= scan_col;
                                end
                            end
                            ru_cnt <= ru_cnt + 1'b1;
                        end
                    end
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_col == CW'(COLS - 1)) begin
                        scan_col <= '0;
                        scan_row <= scan_row + 1'b1;
                    end else begin
                        scan_col <= scan_col + 1'b1;
                    end
                end
                S_DONE: matrix_start <= ~repair_fail;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stw_bisr_sequencer.sv
// Directed self-checking bench for stw_bisr_sequencer at default parameters (4x4 array, 4 RUs).
module tb_stw_bisr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        STW_start;
    logic        STW_result_valid;
    logic [15:0] STW_result_mat;
    logic        STW_test_load_en, STW_pe_start;
    logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
    logic [15:0] fault_map;
    logic [7:0]  ru_row_mapping, ru_col_mapping;
    logic [3:0]  ru_valid;
    logic        busy, STW_complete, matrix_start, repair_fail, STW_timeout;

    int checks = 0;
    int errors = 0;

    stw_bisr_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .STW_start        (STW_start),
        .STW_result_valid (STW_result_valid),
        .STW_result_mat   (STW_result_mat),
        .STW_test_load_en (STW_test_load_en),
        .STW_pe_start     (STW_pe_start),
        .STW_mult_op1     (STW_mult_op1),
        .STW_mult_op2     (STW_mult_op2),
        .STW_add_op       (STW_add_op),
        .STW_expected     (STW_expected),
        .fault_map        (fault_map),
        .ru_row_mapping   (ru_row_mapping),
        .ru_col_mapping   (ru_col_mapping),
        .ru_valid         (ru_valid),
        .busy             (busy),
        .STW_complete     (STW_complete),
        .matrix_start     (matrix_start),
        .repair_fail      (repair_fail),
        .STW_timeout      (STW_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse STW_start for one cycle; returns sampled in LOAD.
    task automatic start_run();
        STW_start = 1'b1;
        tick();
        STW_start = 1'b0;
    endtask

    // From LOAD: RUN, WAIT (+extra idle WAIT cycles), then one valid result cycle.
    task automatic drive_pattern(input logic [15:0] mat, input int extra_wait);
        tick();
        tick();
        repeat (extra_wait) tick();
        STW_result_valid = 1'b1;
        STW_result_mat   = mat;
        tick();
        STW_result_valid = 1'b0;
        STW_result_mat   = 16'hFFFF;
    endtask

    // Bounded wait for the completion pulse.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (STW_complete === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (STW_mult_op1 !== 16'h0) begin errors++; $display("FAIL reset_op1: got %h want 0000", STW_mult_op1); end
        checks++; if ({STW_test_load_en, STW_pe_start, STW_complete, matrix_start, repair_fail, STW_timeout} !== 6'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 000000",
                {STW_test_load_en, STW_pe_start, STW_complete, matrix_start, repair_fail, STW_timeout}); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || STW_test_load_en !== 1'b0) begin errors++;
            $display("FAIL idle_no_start: busy %b load_en %b want 0 0", busy, STW_test_load_en); end
    endtask

    task automatic test_all_pass();
        int  n_cmp;
        int  cmp_at;
        start_run();
        checks++; if (STW_test_load_en !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL p0_load: load_en %b busy %b want 1 1", STW_test_load_en, busy); end
        checks++; if ({STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected} !== 64'hACE1_531E_59C3_8F21) begin errors++;
            $display("FAIL p0_ops: got %h %h %h %h want ace1 531e 59c3 8f21", STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected); end
        STW_result_valid = 1'b1;   // spurious valid during LOAD must be ignored
        STW_result_mat   = 16'h0000;
        tick();
        STW_result_valid = 1'b0;
        STW_result_mat   = 16'hFFFF;
        checks++; if (STW_pe_start !== 1'b1 || STW_test_load_en !== 1'b0) begin errors++;
            $display("FAIL p0_run: pe_start %b load_en %b want 1 0", STW_pe_start, STW_test_load_en); end
        tick();
        checks++; if (STW_pe_start !== 1'b0 || STW_mult_op1 !== 16'hACE1) begin errors++;
            $display("FAIL p0_wait: pe_start %b op1 %h want 0 ace1", STW_pe_start, STW_mult_op1); end
        STW_result_valid = 1'b1;
        tick();
        STW_result_valid = 1'b0;
        checks++; if ({STW_mult_op1, STW_mult_op2, STW_add_op} !== 48'hE270_1D8F_C4E1 || STW_test_load_en !== 1'b1) begin errors++;
            $display("FAIL p1_ops: got %h %h %h load_en %b want e270 1d8f c4e1 1", STW_mult_op1, STW_mult_op2, STW_add_op, STW_test_load_en); end
        checks++; if (fault_map !== 16'h0) begin errors++; $display("FAIL ignore_valid: fault_map %h want 0000", fault_map); end
        repeat (3) drive_pattern(16'hFFFF, 0);
        n_cmp = 0; cmp_at = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (STW_complete === 1'b1) begin n_cmp++; cmp_at = i; end
        end
        checks++; if (n_cmp !== 1 || cmp_at !== 16) begin errors++;
            $display("FAIL alloc_len: complete %0d times at %0d want 1 at 16", n_cmp, cmp_at); end
        tick();
        checks++; if (busy !== 1'b0 || matrix_start !== 1'b1 || ru_valid !== 4'h0 || repair_fail !== 1'b0) begin errors++;
            $display("FAIL pass_result: busy %b ms %b ru_valid %h rf %b want 0 1 0 0", busy, matrix_start, ru_valid, repair_fail); end
    endtask

    task automatic test_timeout();
        start_run();
        checks++; if (matrix_start !== 1'b0) begin errors++; $display("FAIL start_clears_ms: got %b want 0", matrix_start); end
        tick();
        tick();
        repeat (63) tick();
        checks++; if (busy !== 1'b1 || STW_timeout !== 1'b0 || STW_complete !== 1'b0) begin errors++;
            $display("FAIL tmo_early: busy %b tmo %b cmp %b want 1 0 0", busy, STW_timeout, STW_complete); end
        tick();
        checks++; if (STW_complete !== 1'b1 || STW_timeout !== 1'b1 || repair_fail !== 1'b1) begin errors++;
            $display("FAIL tmo_fire: cmp %b tmo %b rf %b want 1 1 1", STW_complete, STW_timeout, repair_fail); end
        tick();
        checks++; if (busy !== 1'b0 || matrix_start !== 1'b0 || STW_complete !== 1'b0) begin errors++;
            $display("FAIL tmo_after: busy %b ms %b cmp %b want 0 0 0", busy, matrix_start, STW_complete); end
    endtask

    task automatic test_overflow();
        int n_cmp;
        int cmp_at;
        start_run();
        checks++; if (STW_timeout !== 1'b0 || repair_fail !== 1'b0) begin errors++;
            $display("FAIL start_clears: tmo %b rf %b want 0 0", STW_timeout, repair_fail); end
        drive_pattern(16'hFFF6, 0);
        drive_pattern(16'h7FFF, 2);
        drive_pattern(16'hFFFF, 0);
        checks++; if (fault_map !== 16'h8009) begin errors++; $display("FAIL accum: fault_map %h want 8009", fault_map); end
        drive_pattern(16'hFDD7, 0);
        n_cmp = 0; cmp_at = 0;
        for (int i = 1; i <= 16; i++) begin
            STW_start = (i == 6);
            tick();
            if (STW_complete === 1'b1) begin n_cmp++; cmp_at = i; end
        end
        STW_start = 1'b0;
        checks++; if (n_cmp !== 1 || cmp_at !== 16) begin errors++;
            $display("FAIL busy_start_len: complete %0d times at %0d want 1 at 16", n_cmp, cmp_at); end
        tick();
        checks++; if (busy !== 1'b0 || STW_test_load_en !== 1'b0) begin errors++;
            $display("FAIL busy_start_ignored: busy %b load_en %b want 0 0", busy, STW_test_load_en); end
        checks++; if (fault_map !== 16'h8229 || ru_valid !== 4'hF) begin errors++;
            $display("FAIL ovf_map: fault_map %h ru_valid %h want 8229 f", fault_map, ru_valid); end
        checks++; if (ru_row_mapping !== 8'h90 || ru_col_mapping !== 8'h5C) begin errors++;
            $display("FAIL ovf_ru: rows %h cols %h want 90 5c", ru_row_mapping, ru_col_mapping); end
        checks++; if (repair_fail !== 1'b1 || matrix_start !== 1'b0) begin errors++;
            $display("FAIL ovf_fail: rf %b ms %b want 1 0", repair_fail, matrix_start); end
    endtask

    task automatic test_coincident();
        bit seen;
        start_run();
        tick();
        tick();
        repeat (63) tick();
        STW_result_valid = 1'b1;
        tick();
        STW_result_valid = 1'b0;
        checks++; if (STW_timeout !== 1'b0 || STW_test_load_en !== 1'b1 || STW_mult_op1 !== 16'hE270) begin errors++;
            $display("FAIL coincident: tmo %b load_en %b op1 %h want 0 1 e270", STW_timeout, STW_test_load_en, STW_mult_op1); end
        repeat (3) drive_pattern(16'hFFFF, 0);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL coinc_done: complete not seen want seen"); end
        tick();
        checks++; if (STW_timeout !== 1'b0 || repair_fail !== 1'b0 || matrix_start !== 1'b1) begin errors++;
            $display("FAIL coinc_result: tmo %b rf %b ms %b want 0 0 1", STW_timeout, repair_fail, matrix_start); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        start_run();
        drive_pattern(16'hFFFB, 0);
        drive_pattern(16'hFFFF, 0);
        tick();
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || fault_map !== 16'h0 || matrix_start !== 1'b0) begin errors++;
            $display("FAIL midrst_state: busy %b fault_map %h ms %b want 0 0000 0", busy, fault_map, matrix_start); end
        checks++; if ({STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected} !== 64'h0) begin errors++;
            $display("FAIL midrst_ops: got %h %h %h %h want zeros", STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b want 0", busy); end
        start_run();
        checks++; if (STW_mult_op1 !== 16'hACE1 || STW_expected !== 16'h8F21 || fault_map !== 16'h0) begin errors++;
            $display("FAIL midrst_restart: op1 %h exp %h fault_map %h want ace1 8f21 0000", STW_mult_op1, STW_expected, fault_map); end
        repeat (4) drive_pattern(16'hFFFF, 0);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL midrst_done: complete not seen want seen"); end
        tick();
    endtask

    task automatic test_two_faults();
        bit seen;
        start_run();
        drive_pattern(16'hFFFF, 0);
        drive_pattern(16'hFFFF, 1);
        drive_pattern(16'hEFBF, 0);
        checks++; if (fault_map !== 16'h1040) begin errors++; $display("FAIL two_map: fault_map %h want 1040", fault_map); end
        drive_pattern(16'hFFFF, 0);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL two_done: complete not seen want seen"); end
        checks++; if (ru_valid !== 4'h3 || ru_row_mapping !== 8'h0D || ru_col_mapping !== 8'h02) begin errors++;
            $display("FAIL two_ru: ru_valid %h rows %h cols %h want 3 0d 02", ru_valid, ru_row_mapping, ru_col_mapping); end
        tick();
        checks++; if (repair_fail !== 1'b0 || matrix_start !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL two_result: rf %b ms %b busy %b want 0 1 0", repair_fail, matrix_start, busy); end
    endtask

    initial begin
        STW_start        = 1'b0;
        STW_result_valid = 1'b0;
        STW_result_mat   = 16'hFFFF;
        test_reset();
        test_all_pass();
        test_timeout();
        test_overflow();
        test_coincident();
        test_reset_mid();
        test_two_faults();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
